// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// Valid/ready on both sides; optional two's-complement input and overflow flag.
module bcd_convert_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] bin_reg;
  logic [BW-1:0]   bcd_reg;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_shift;
  logic            ovf_reg;
  logic            neg_reg;
  logic [CW-1:0]   cnt_reg;

  logic            accept;
  logic            sign;
  logic [WIDTH-1:0] mag;
  logic            ovf_next;

  assign accept = (state_reg == IDLE) && in_valid && in_ready;

  // The most negative input negates to itself, which read unsigned is its magnitude.
  assign sign = SIGNED && in_data[WIDTH-1];
  assign mag  = sign ? (WIDTH'(0) - in_data) : in_data;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  (bcd_reg[4*gi +: 4] + 4'd3) : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign bcd_shift = {bcd_adj[BW-2:0], bin_reg[WIDTH-1]};
  assign ovf_next  = ovf_reg | bcd_adj[BW-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (cnt_reg == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      ovf_reg   <= 1'b0;
      neg_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      in_ready <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            bin_reg <= mag;
            bcd_reg <= '0;
            ovf_reg <= 1'b0;
            neg_reg <= sign;
            cnt_reg <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          bin_reg <= bin_reg << 1;
          bcd_reg <= bcd_shift;
          ovf_reg <= ovf_next;
          cnt_reg <= cnt_reg - CW'(1);
          // Result registers are written only on the final shift.
          if (cnt_reg == CW'(1)) begin
            out_bcd   <= bcd_shift;
            out_neg   <= neg_reg;
            out_ovf   <= ovf_next;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Scoreboard bench: three converter configurations share one stimulus stream;
// expected results come from a plain decimal model and are checked by a monitor.
module tb_bcd_convert_seq;

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic [11:0] bcd0, bcd1;
  logic [7:0]  bcd2;
  logic        neg0, neg1, neg2;
  logic        ovf0, ovf1, ovf2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int  checks = 0;
  int  errors = 0;
  time acc_time;

  always #5 clk = ~clk;

  bcd_convert_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_bcd(bcd0), .out_neg(neg0), .out_ovf(ovf0));

  bcd_convert_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_bcd(bcd1), .out_neg(neg1), .out_ovf(ovf1));

  bcd_convert_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(1'b0)) u_ovf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_bcd(bcd2), .out_neg(neg2), .out_ovf(ovf2));

  // Decimal reference: magnitude and sign by plain arithmetic, digits by div/mod.
  function automatic exp_t model(input logic [7:0] v, input bit sgn, input int digits);
    exp_t e;
    int val, mag, lim;
    val = sgn ? int'($signed(v)) : int'(v);
    e.neg = (val < 0);
    mag = (val < 0) ? -val : val;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    mag = mag % lim;
    e.bcd = '0;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic cmp(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got bcd=%h neg=%b ovf=%b expected bcd=%h neg=%b ovf=%b",
               name, got.bcd, got.neg, got.ovf, want.bcd, want.neg, want.ovf);
    end
  endtask

  task automatic pop_cmp(input string name, inout exp_t q[$], input exp_t got);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected result bcd=%h, expected no output", name, got.bcd);
    end else begin
      cmp(name, got, q.pop_front());
    end
  endtask

  // Monitor: a result leaves on the coming edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst && out_ready) begin
      if (ov0) pop_cmp("uns_w8d3", q0, '{bcd: bcd0, neg: neg0, ovf: ovf0});
      if (ov1) pop_cmp("sgn_w8d3", q1, '{bcd: bcd1, neg: neg1, ovf: ovf1});
      if (ov2) pop_cmp("uns_w8d2", q2, '{bcd: {4'h0, bcd2}, neg: neg2, ovf: ovf2});
      if (ov0 || ov1 || ov2)
        $display("xfer t=%0t uns=%h sgn=%b%h d2=%b%h", $time, bcd0, neg1, bcd1, ovf2, bcd2);
    end
  end

  task automatic send(input logic [7:0] v, input bit hold_valid);
    int t;
    in_data  = v;
    in_valid = 1'b1;
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      if (ir0) break;
      t++;
    end
    if (t >= 200) begin
      chk("accept_timeout", 64'(ir0), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_time = $time;
    q0.push_back(model(v, 1'b0, 3));
    q1.push_back(model(v, 1'b1, 3));
    q2.push_back(model(v, 1'b0, 2));
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!ov0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ov0) chk("valid_timeout", 64'(ov0), 64'd1);
  endtask

  logic [7:0]  dir_vals [10] = '{8'd255, 8'd0, 8'd100, 8'h80, 8'hFF, 8'h7F,
                                  8'h00, 8'd199, 8'd99, 8'd1};
  logic [63:0] snap;
  time         prev_time;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    chk("reset_out_valid", 64'(ov0), 64'd0);
    chk("reset_in_ready", 64'(ir0), 64'd0);
    chk("reset_out_bcd", 64'(bcd0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(ir0), 64'd1);

    // Latency: out_valid rises exactly 8 edges after the accept edge.
    send(8'd255, 1'b0);
    repeat (7) @(posedge clk);
    #1 chk("latency_e7", 64'(ov0), 64'd0);
    @(posedge clk);
    #1 chk("latency_e8", 64'(ov0), 64'd1);

    foreach (dir_vals[i]) send(dir_vals[i], 1'b0);

    // Reset mid-conversion, after three shifts.
    send(8'd200, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(ov0), 64'd0);
    chk("midreset_out_bcd", 64'({bcd0, bcd1, bcd2}), 64'd0);
    chk("midreset_in_ready", 64'(ir0), 64'd0);
    void'(q0.pop_back()); void'(q1.pop_back()); void'(q2.pop_back());
    @(negedge clk);
    rst = 1'b1;
    #1 chk("release_in_ready_low", 64'(ir0), 64'd0);
    @(posedge clk); #1;
    chk("release_in_ready_high", 64'(ir0), 64'd1);
    send(8'd42, 1'b0);

    // Backpressure in DONE while in_valid/in_data wiggle.
    wait_valid();
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'($urandom_range(0, 255)), 1'b0);
    wait_valid();
    snap = {26'd0, bcd0, bcd1, bcd2, neg0, neg1, neg2, ovf0, ovf1, ovf2};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      @(negedge clk);
      chk("bp_stable", {26'd0, bcd0, bcd1, bcd2, neg0, neg1, neg2, ovf0, ovf1, ovf2}, snap);
      chk("bp_valid_ready", {ov0, ir0, ov1, ir1, ov2, ir2}, 64'b101010);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(ov0), 64'd0);
    chk("bp_release_ready", 64'(ir0), 64'd1);

    for (int k = 0; k < 20; k++) send(8'($urandom), 1'b0);

    // Streaming sweep; the signed instance sees the same bits as -128..127.
    for (int v = 0; v < 256; v++) begin
      prev_time = acc_time;
      send(8'(v), 1'b1);
      if (v > 0) chk("stream_period", 64'(acc_time - prev_time), 64'd100);
    end
    in_valid = 1'b0;

    for (int t = 0; t < 200 && (q0.size() + q1.size() + q2.size()) != 0; t++)
      @(negedge clk);
    chk("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
